render_sequencer: RTL
=====================

// Module: render_sequencer
// PURPOSE
//  Per-frame scheduler between the game-logic sprite table (elements_all) and the sprite blitter.
//  On each frame_start it walks sprite slots 0..N_ELEM-1 in order and skips empty slots.
//  It issues one blit request per valid slot over a req/ack handshake.
//  After the last slot it pulses write_finished, which releases the game-logic movement controllers.
// PARAMETERS
//  N_ELEM   11  number of sprite slots (Rend_number)
//  PW       12  width of every position/size/ROM-coordinate field
//  LAST_IDX 10  slot drawn alone when to_black=1 (settlement page)
// PORTS
//  clk_33        in   1    system clock
//  rst_n         in   1    reset; asynchronous, active-low
//  frame_start   in   1    1-cycle pulse: begin a frame
//  to_black      in   1    game-finished; sampled at frame start
//  elem_idx      out  4    slot index driven to the sprite-table mux
//  elem_x/elem_y in   PW   slot position, combinational from elem_idx
//  elem_w/elem_h in   PW   slot size, combinational from elem_idx
//  elem_rx/elem_ry in PW   slot ROM coordinates, combinational from elem_idx
//  blit_req      out  1    blit request
//  blit_x,blit_y,blit_w,blit_h,blit_rx,blit_ry  out  PW  latched payload
//  blit_ack      in   1    blitter finished the current sprite
//  clear_req     out  1    framebuffer clear request (macro only)
//  clear_ack     in   1    clear finished (macro only)
//  busy          out  1    frame in progress
//  write_finished out 1    1-cycle pulse: frame fully written
//  overrun_cnt   out  8    saturating count of dropped frame_start pulses
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, state=IDLE, to_black latch=0.
//  States: IDLE, CLEAR (macro only), FETCH, WAIT, DONE.
//  IDLE:
//   - on frame_start: latch to_black as tb, busy<=1.
//   - elem_idx<=(tb ? LAST_IDX : 0); next state CLEAR (macro) else FETCH.
//  FETCH (1 cycle per slot):
//   - slot is empty if elem_w==0 or elem_h==0 -> advance.
//   - otherwise latch all six elem_* into blit_*, blit_req<=1, go WAIT.
//  WAIT:
//   - blit_req and blit_* stay stable until blit_ack is sampled 1.
//   - on ack: blit_req<=0 next cycle, then advance.
//   - blit_ack while blit_req=0 is ignored.
//  advance:
//   - if tb, or elem_idx==N_ELEM-1: go DONE.
//   - else elem_idx++ and go FETCH.
//   - elem_idx never wraps.
//  DONE: write_finished=1 for exactly 1 cycle, busy<=0, elem_idx<=0, go IDLE.
//  Latency:
//   - frame of all-empty slots: write_finished 1+N_ELEM+1 cycles after frame_start is sampled.
//   - each valid slot adds (ack wait + 1) cycles.
//  Boundaries:
//   - frame_start while busy=1: frame is not restarted; overrun_cnt+1, saturating at 255.
//   - frame_start in the DONE cycle counts as an overrun.
//   - reset mid-frame: blit_req drops immediately; no write_finished is produced.
//   - blit_ack in the same cycle blit_req rises: accepted; 1-cycle handshake is legal.
//   - to_black changing mid-frame has no effect until the next frame.
// CONFIGURATION
//  BG_CLEAR_EN defined:
//   - CLEAR state sits between IDLE and FETCH.
//   - clear_req=1 until clear_ack is sampled 1; then FETCH next cycle.
//   - to_black frames also clear.
//  BG_CLEAR_EN undefined:
//   - no CLEAR state; clear_req tied 0; clear_ack ignored.
//   - IDLE goes straight to FETCH.
// TESTING
//  1 reset -> all outputs 0; frame_start with all slots w=0, blit_req never rises:
//    -> write_finished at cycle 13, busy low at cycle 13. (Cycle 1 = first cycle after frame_start is sampled.)
//  2 slots 0,6,7 valid (w=h=16), ack 3 cycles after each req:
//    -> exactly 3 requests with elem_idx 0,6,7; blit_* equal slot values; order preserved.
//  3 to_black=1 at frame_start, slot 10 valid:
//    -> single request with elem_idx=10; write_finished 1 cycle after its ack.
//  4 frame_start pulsed 300 times while stalled in WAIT (ack withheld):
//    -> overrun_cnt=255, blit_payload unchanged.
//  5 rst_n low during WAIT:
//    -> blit_req=0 asynchronously; after release, IDLE; no write_finished.
//  6 BG_CLEAR_EN, clear_ack after 5 cycles:
//    -> clear_req high 5 cycles; first blit_req only after clear_ack.

Source files
------------

// File: rtl/render_sequencer.sv
// Per-frame sprite scheduler: walks the sprite table and issues one blit per non-empty slot.
// Optional framebuffer clear before each frame is enabled with the BG_CLEAR_EN macro.
module render_sequencer #(
  parameter int unsigned N_ELEM   = 11,
  parameter int unsigned PW       = 12,
  parameter int unsigned LAST_IDX = 10
) (
  input  logic          clk_33,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          to_black,
  output logic [3:0]    elem_idx,
  input  logic [PW-1:0] elem_x,
  input  logic [PW-1:0] elem_y,
  input  logic [PW-1:0] elem_w,
  input  logic [PW-1:0] elem_h,
  input  logic [PW-1:0] elem_rx,
  input  logic [PW-1:0] elem_ry,
  output logic          blit_req,
  output logic [PW-1:0] blit_x,
  output logic [PW-1:0] blit_y,
  output logic [PW-1:0] blit_w,
  output logic [PW-1:0] blit_h,
  output logic [PW-1:0] blit_rx,
  output logic [PW-1:0] blit_ry,
  input  logic          blit_ack,
  output logic          clear_req,
  input  logic          clear_ack,
  output logic          busy,
  output logic          write_finished,
  output logic [7:0]    overrun_cnt
);

  localparam logic [3:0] LAST_SLOT  = 4'(N_ELEM - 1);
  localparam logic [3:0] BLACK_SLOT = 4'(LAST_IDX);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef BG_CLEAR_EN
    S_CLEAR,
`endif
    S_FETCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state;
  logic   black_frame;
  logic   last_slot;
  logic   slot_empty;

  // A settlement-page frame draws only one slot, so it always ends after it.
  assign last_slot  = black_frame || (elem_idx == LAST_SLOT);
  assign slot_empty = (elem_w == '0) || (elem_h == '0);

`ifndef BG_CLEAR_EN
  logic unused_clear_ack;
  assign unused_clear_ack = clear_ack;
  assign clear_req        = 1'b0;
`endif

  always_ff @(posedge clk_33 or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      black_frame    <= 1'b0;
      elem_idx       <= '0;
      blit_req       <= 1'b0;
      blit_x         <= '0;
      blit_y         <= '0;
      blit_w         <= '0;
      blit_h         <= '0;
      blit_rx        <= '0;
      blit_ry        <= '0;
      busy           <= 1'b0;
      write_finished <= 1'b0;
      overrun_cnt    <= '0;
`ifdef BG_CLEAR_EN
      clear_req      <= 1'b0;
`endif
    end else begin
      write_finished <= 1'b0;

      // Any frame_start outside IDLE (DONE included) is dropped and counted.
      if (frame_start && (state != S_IDLE) && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            black_frame <= to_black;
            busy        <= 1'b1;
            elem_idx    <= to_black ? BLACK_SLOT : 4'd0;
`ifdef BG_CLEAR_EN
            clear_req   <= 1'b1;
            state       <= S_CLEAR;
`else
            state       <= S_FETCH;
`endif
          end
        end
`ifdef BG_CLEAR_EN
        S_CLEAR: begin
          if (clear_ack) begin
            clear_req <= 1'b0;
            state     <= S_FETCH;
          end
        end
`endif
        S_FETCH: begin
          if (slot_empty) begin
            if (last_slot) begin
              state <= S_DONE;
            end else begin
              elem_idx <= elem_idx + 4'd1;
              state    <= S_FETCH;
            end
          end else begin
            blit_x   <= elem_x;
            blit_y   <= elem_y;
            blit_w   <= elem_w;
            blit_h   <= elem_h;
            blit_rx  <= elem_rx;
            blit_ry  <= elem_ry;
            blit_req <= 1'b1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (blit_ack) begin
            blit_req <= 1'b0;
            if (last_slot) begin
              state <= S_DONE;
            end else begin
              elem_idx <= elem_idx + 4'd1;
              state    <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          write_finished <= 1'b1;
          busy           <= 1'b0;
          elem_idx       <= '0;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
